// File: rtl/lcd_pkg.sv
// Shared LCD definitions: HD44780 command bytes, ASCII codes, arbiter state encoding
// and small helpers for command classification and the power-up init table.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h3C;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h02;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_9      = 8'h39;
  localparam logic [7:0] ASCII_PLUS   = 8'h2B;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_EQUAL  = 8'h3D;
  localparam logic [7:0] ASCII_BLANK  = 8'h20;

  localparam int INIT_LEN = 4;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_EXEC_WAIT,
    ST_IDLE
  } lcd_state_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

  // Clear/home (command bytes 0x01..0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return (!rs) && (d[7:2] == 6'd0) && (d[1:0] != 2'd0);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Two-requester write handshake into the LCD arbiter (req/rs/data held until gnt).
interface lcd_write_arbiter_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       gnt0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       gnt1;

  modport master (output req0, rs0, data0, req1, rs1, data1, input gnt0, gnt1);
  modport slave  (input req0, rs0, data0, req1, rs1, data1, output gnt0, gnt1);
endinterface

// File: rtl/lcd_tick_gen.sv
// Timing prescaler: one-cycle tick every DIV clocks, on the counter wrap.
module lcd_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CW'(DIV - 1)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CW'(DIV - 1));

endmodule

// File: rtl/lcd_write_arbiter.sv
// Character-LCD bus owner: HD44780 power-up init, then req/gnt sharing between two writers.
// Define LCD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int DIV             = 10,
  parameter int PWRUP_TICKS     = 70,
  parameter int E_TICKS         = 1,
  parameter int EXEC_TICKS      = 20,
  parameter int LONG_EXEC_TICKS = 200
) (
  input  logic                clk,
  input  logic                rst,
  lcd_write_arbiter_if.slave  bus,
  output logic                init_done,
  output logic                busy,
  output logic                lcd_e,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic [7:0]          lcd_data
);

  logic        tick;
  lcd_state_e  state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic [15:0] target;
  logic [1:0]  init_idx_reg, init_idx_next;
  logic        init_done_reg, init_done_next;
  logic        rr_last_reg, rr_last_next;
  logic        rs_lat_reg, rs_lat_next;
  logic [7:0]  data_lat_reg, data_lat_next;
  logic        gnt0_reg, gnt0_next;
  logic        gnt1_reg, gnt1_next;
  logic        sync_reg, sync_next;
  logic        adv;
  logic        grant0, grant1;

  lcd_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    case (state_reg)
      ST_PWR_WAIT:  target = 16'(PWRUP_TICKS);
      ST_E_HIGH:    target = 16'(E_TICKS);
      ST_EXEC_WAIT: target = is_long_cmd(rs_lat_reg, data_lat_reg) ?
                             16'(LONG_EXEC_TICKS) : 16'(EXEC_TICKS);
      default:      target = 16'd1;
    endcase
  end

  // A write granted from IDLE is off-phase with the prescaler, so the first tick
  // only aligns SETUP (sync_reg) and SETUP then lasts one full tick.
  assign adv = tick && !sync_reg && (timer_reg == target - 16'd1);

`ifdef LCD_ARB_FIXED_PRIO_EN
  assign grant0 = bus.req0;
`else
  assign grant0 = bus.req0 && (!bus.req1 || rr_last_reg);
`endif
  assign grant1 = bus.req1 && !grant0;

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    init_idx_next  = init_idx_reg;
    init_done_next = init_done_reg;
    rr_last_next   = rr_last_reg;
    rs_lat_next    = rs_lat_reg;
    data_lat_next  = data_lat_reg;
    gnt0_next      = 1'b0;
    gnt1_next      = 1'b0;
    sync_next      = sync_reg;

    if (state_reg != ST_IDLE && tick) begin
      if (sync_reg) begin
        sync_next = 1'b0;
      end else if (adv) begin
        timer_next = 16'd0;
      end else begin
        timer_next = timer_reg + 16'd1;
      end
    end

    case (state_reg)
      ST_PWR_WAIT: begin
        if (adv) begin
          state_next    = ST_SETUP;
          init_idx_next = 2'd0;
          rs_lat_next   = 1'b0;
          data_lat_next = init_cmd(2'd0);
        end
      end
      ST_SETUP:  if (adv) state_next = ST_E_HIGH;
      ST_E_HIGH: if (adv) state_next = ST_HOLD;
      ST_HOLD:   if (adv) state_next = ST_EXEC_WAIT;
      ST_EXEC_WAIT: begin
        if (adv) begin
          if (!init_done_reg && init_idx_reg != 2'(INIT_LEN - 1)) begin
            state_next    = ST_SETUP;
            init_idx_next = init_idx_reg + 2'd1;
            rs_lat_next   = 1'b0;
            data_lat_next = init_cmd(init_idx_reg + 2'd1);
          end else begin
            state_next     = ST_IDLE;
            init_done_next = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (init_done_reg && (grant0 || grant1)) begin
          state_next    = ST_SETUP;
          timer_next    = 16'd0;
          sync_next     = 1'b1;
          gnt0_next     = grant0;
          gnt1_next     = grant1;
          rr_last_next  = grant1;
          rs_lat_next   = grant0 ? bus.rs0 : bus.rs1;
          data_lat_next = grant0 ? bus.data0 : bus.data1;
        end
      end
      default: state_next = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_PWR_WAIT;
      timer_reg     <= 16'd0;
      init_idx_reg  <= 2'd0;
      init_done_reg <= 1'b0;
      rr_last_reg   <= 1'b1;
      rs_lat_reg    <= 1'b0;
      data_lat_reg  <= 8'h00;
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      sync_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      init_idx_reg  <= init_idx_next;
      init_done_reg <= init_done_next;
      rr_last_reg   <= rr_last_next;
      rs_lat_reg    <= rs_lat_next;
      data_lat_reg  <= data_lat_next;
      gnt0_reg      <= gnt0_next;
      gnt1_reg      <= gnt1_next;
      sync_reg      <= sync_next;
    end
  end

  assign bus.gnt0  = gnt0_reg;
  assign bus.gnt1  = gnt1_reg;
  assign init_done = init_done_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign lcd_e     = (state_reg == ST_E_HIGH);
  assign lcd_rs    = rs_lat_reg;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = data_lat_reg;

endmodule
